control_unit: RTL

Multicycle main control FSM for the MIPS datapath. It decodes `opcode`/`funct` from the instruction register and sequences fetch, decode, execute, memory and writeback. It drives every datapath load, select and ALU signal, and reads back the ALU status flags and the branch-mux result. It is the producer side of the datapath's control interface and is instantiated beside the datapath in the top-level CPU.

---
 rtl/control_unit.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives every datapath strobe and select from the current state.
module control_unit (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [5:0] i_opcode,
   input  logic [5:0] i_funct,
   input  logic       i_alu_overflow,
   input  logic       i_branch_cond,
   output logic       o_PC_write,
   output logic       o_wr,
   output logic       o_AB_load,
   output logic       o_aluout_load,
   output logic       o_MDR_load,
   output logic       o_sel_ir,
   output logic       o_regwrite,
   output logic       o_EPC_load,
   output logic       o_sel_alusrca,
   output logic [1:0] o_sel_alusrcb,
   output logic [2:0] o_alu_op,
   output logic [2:0] o_sel_mux_iord,
   output logic [1:0] o_sel_pc_source,
   output logic [1:0] o_sel_regdst,
   output logic [1:0] o_sel_memtoreg,
   output logic [1:0] o_sel_branchop,
   output logic [4:0] o_state
);

   typedef enum logic [4:0] {
      S_RESET     = 5'd0,
      S_FETCH0    = 5'd1,
      S_FETCH1    = 5'd2,
      S_FETCH2    = 5'd3,
      S_DECODE    = 5'd4,
      S_R_EXEC    = 5'd5,
      S_R_WB      = 5'd6,
      S_ADDI_EXEC = 5'd7,
      S_ADDI_WB   = 5'd8,
      S_MEM_ADDR  = 5'd9,
      S_LW_RD0    = 5'd10,
      S_LW_RD1    = 5'd11,
      S_LW_MDR    = 5'd12,
      S_LW_WB     = 5'd13,
      S_SW_WR     = 5'd14,
      S_BRANCH    = 5'd15,
      S_JUMP      = 5'd16,
      S_JR        = 5'd17,
      S_EXCEPT    = 5'd18
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_SLT = 6'h2a;
   localparam logic [5:0] FN_JR  = 6'h08;

   localparam logic [2:0] ALU_PASSA = 3'b000;
   localparam logic [2:0] ALU_ADD   = 3'b001;
   localparam logic [2:0] ALU_SUB   = 3'b010;
   localparam logic [2:0] ALU_AND   = 3'b011;
   localparam logic [2:0] ALU_CMP   = 3'b111;

   localparam logic [1:0] SRCB_B    = 2'b00;
   localparam logic [1:0] SRCB_4    = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_IMM2 = 2'b11;

   localparam logic [1:0] PCS_ALU  = 2'b00;
   localparam logic [1:0] PCS_OUT  = 2'b01;
   localparam logic [1:0] PCS_JMP  = 2'b10;
   localparam logic [1:0] PCS_EXC  = 2'b11;

   localparam logic [2:0] IORD_PC  = 3'b000;
   localparam logic [2:0] IORD_ALU = 3'b001;

   state_t r_state, w_next;

   logic       w_r_alu;
   logic       w_r_trap;
   logic       w_is_slt;
   logic [2:0] w_r_aluop;

   assign w_r_alu  = (i_funct == FN_ADD) || (i_funct == FN_SUB) ||
                     (i_funct == FN_AND) || (i_funct == FN_SLT);
   // only signed add/sub can trap on overflow; and/slt ignore the flag
   assign w_r_trap = ((i_funct == FN_ADD) || (i_funct == FN_SUB)) && i_alu_overflow;
   assign w_is_slt = (i_funct == FN_SLT);

   always_comb begin
      unique case (i_funct)
         FN_SUB:  w_r_aluop = ALU_SUB;
         FN_AND:  w_r_aluop = ALU_AND;
         FN_SLT:  w_r_aluop = ALU_CMP;
         default: w_r_aluop = ALU_ADD;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= S_RESET;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next          = S_FETCH0;
      o_PC_write      = 1'b0;
      o_wr            = 1'b0;
      o_AB_load       = 1'b0;
      o_aluout_load   = 1'b0;
      o_MDR_load      = 1'b0;
      o_sel_ir        = 1'b0;
      o_regwrite      = 1'b0;
      o_EPC_load      = 1'b0;
      o_sel_alusrca   = 1'b0;
      o_sel_alusrcb   = SRCB_B;
      o_alu_op        = ALU_PASSA;
      o_sel_mux_iord  = IORD_PC;
      o_sel_pc_source = PCS_ALU;
      o_sel_regdst    = 2'b00;
      o_sel_memtoreg  = 2'b00;
      o_sel_branchop  = 2'b00;

      case (r_state)
         S_RESET: begin
            // seed $sp with 227 while reset is held
            o_regwrite     = 1'b1;
            o_sel_regdst   = 2'b10;
            o_sel_memtoreg = 2'b10;
            w_next         = S_FETCH0;
         end
         S_FETCH0, S_FETCH1: begin
            o_sel_mux_iord = IORD_PC;
            o_sel_alusrcb  = SRCB_4;
            o_alu_op       = ALU_ADD;
            w_next         = (r_state == S_FETCH0) ? S_FETCH1 : S_FETCH2;
         end
         S_FETCH2: begin
            o_sel_mux_iord  = IORD_PC;
            o_sel_alusrcb   = SRCB_4;
            o_alu_op        = ALU_ADD;
            o_sel_ir        = 1'b1;
            o_PC_write      = 1'b1;
            o_sel_pc_source = PCS_ALU;
            w_next          = S_DECODE;
         end
         S_DECODE: begin
            o_AB_load     = 1'b1;
            o_aluout_load = 1'b1;
            o_sel_alusrcb = SRCB_IMM2;
            o_alu_op      = ALU_ADD;
            case (i_opcode)
               OP_RTYPE: begin
                  if (w_r_alu)                w_next = S_R_EXEC;
                  else if (i_funct == FN_JR)  w_next = S_JR;
                  else                        w_next = S_EXCEPT;
               end
               OP_ADDI:        w_next = S_ADDI_EXEC;
               OP_LW, OP_SW:   w_next = S_MEM_ADDR;
               OP_BEQ, OP_BNE: w_next = S_BRANCH;
               OP_J:           w_next = S_JUMP;
               default:        w_next = S_EXCEPT;
            endcase
         end
         S_R_EXEC: begin
            o_sel_alusrca = 1'b1;
            o_sel_alusrcb = SRCB_B;
            o_alu_op      = w_r_aluop;
            o_aluout_load = 1'b1;
            w_next        = w_r_trap ? S_EXCEPT : S_R_WB;
         end
         S_R_WB: begin
            o_regwrite   = 1'b1;
            o_sel_regdst = 2'b01;
            if (w_is_slt) begin
               // LT flag comes straight off the ALU, so keep the compare running
               o_sel_memtoreg = 2'b11;
               o_sel_alusrca  = 1'b1;
               o_sel_alusrcb  = SRCB_B;
               o_alu_op       = ALU_CMP;
            end
            w_next = S_FETCH0;
         end
         S_ADDI_EXEC: begin
            o_sel_alusrca = 1'b1;
            o_sel_alusrcb = SRCB_IMM;
            o_alu_op      = ALU_ADD;
            o_aluout_load = 1'b1;
            w_next        = i_alu_overflow ? S_EXCEPT : S_ADDI_WB;
         end
         S_ADDI_WB: begin
            o_regwrite = 1'b1;
            w_next     = S_FETCH0;
         end
         S_MEM_ADDR: begin
            o_sel_alusrca = 1'b1;
            o_sel_alusrcb = SRCB_IMM;
            o_alu_op      = ALU_ADD;
            o_aluout_load = 1'b1;
            w_next        = (i_opcode == OP_SW) ? S_SW_WR : S_LW_RD0;
         end
         S_LW_RD0: begin
            o_sel_mux_iord = IORD_ALU;
            w_next         = S_LW_RD1;
         end
         S_LW_RD1: begin
            o_sel_mux_iord = IORD_ALU;
            w_next         = S_LW_MDR;
         end
         S_LW_MDR: begin
            o_sel_mux_iord = IORD_ALU;
            o_MDR_load     = 1'b1;
            w_next         = S_LW_WB;
         end
         S_LW_WB: begin
            o_regwrite     = 1'b1;
            o_sel_memtoreg = 2'b01;
            w_next         = S_FETCH0;
         end
         S_SW_WR: begin
            o_sel_mux_iord = IORD_ALU;
            o_wr           = 1'b1;
            w_next         = S_FETCH0;
         end
         S_BRANCH: begin
            o_sel_alusrca   = 1'b1;
            o_sel_alusrcb   = SRCB_B;
            o_alu_op        = ALU_SUB;
            o_sel_branchop  = (i_opcode == OP_BNE) ? 2'b01 : 2'b00;
            o_sel_pc_source = PCS_OUT;
            o_PC_write      = i_branch_cond;
            w_next          = S_FETCH0;
         end
         S_JUMP: begin
            o_sel_pc_source = PCS_JMP;
            o_PC_write      = 1'b1;
            w_next          = S_FETCH0;
         end
         S_JR: begin
            o_sel_alusrca   = 1'b1;
            o_alu_op        = ALU_PASSA;
            o_sel_pc_source = PCS_ALU;
            o_PC_write      = 1'b1;
            w_next          = S_FETCH0;
         end
         S_EXCEPT: begin
            // PC already advanced in FETCH2; back it off by 4 into EPC
            o_sel_alusrca   = 1'b0;
            o_sel_alusrcb   = SRCB_4;
            o_alu_op        = ALU_SUB;
            o_EPC_load      = 1'b1;
            o_sel_pc_source = PCS_EXC;
            o_PC_write      = 1'b1;
            w_next          = S_FETCH0;
         end
         default: w_next = S_RESET;
      endcase
   end

   assign o_state = r_state;

endmodule
